wordcount_cmd_ctrl: RTL and testbench
=====================================

// Module: wordcount_cmd_ctrl
// PURPOSE
//  Parametrised command sequencer for the wordcount kernel. Sits between the host scalar regs and the
//  search_and_add_ctrl / simple_result_copy engines, and owns the single port of accum_array.
//  Adds over previous gen: CLEAR command (on-chip array zeroing), done pulse, sticky status, copy offset.
// PARAMETERS
//  ADDR_WIDTH      14       accum_array address bits; depth = 2**ADDR_WIDTH
//  DATA_WIDTH      64       accum_array data width
//  TIMEOUT_CYCLES  1048576  RUN-state watchdog limit (used only with WORDCOUNT_CMD_TIMEOUT_EN)
// PORTS
//  clk               in   1   clock
//  reset             in   1   async active-high reset
//  axonerve_ready    in   1   CAM init complete
//  kick              in   1   start command (sampled in IDLE only)
//  command           in   32  1=SEARCH_ADD 2=COPY 3=CLEAR, others illegal
//  num_of_words      in   32  word count (SEARCH_ADD/COPY) or entry count (CLEAR, 0=all)
//  copy_offset       in   32  first accum_array entry for COPY
//  global_memory_offset in 64 host memory byte offset
//  busy              out  1   ~ready_seen | state!=IDLE
//  done              out  1   1-cycle pulse at command completion
//  status            out  2   sticky result of last command: 0 OK, 1 illegal cmd, 2 timeout
//  sa_kick/rc_kick   out  1   1-cycle engine start pulses
//  sa_busy/rc_busy   in   1   engine busy
//  sa_num_of_words, sa_memory_offset   out 32/64  latched params to search_and_add_ctrl
//  rc_offset, rc_words, rc_memory_offset out 32/32/64 latched params to simple_result_copy
//  sa_accum_addr/din/we in ADDR_WIDTH/DATA_WIDTH/1  search_and_add array port
//  rc_addr           in   ADDR_WIDTH  result_copy read address
//  accum_addr/din/we out  ADDR_WIDTH/DATA_WIDTH/1  to accum_array
// BEHAVIOUR
//  - Reset: state=INIT; all kicks, done, accum_we, accum_addr, accum_din, status, latched params = 0.
//    Reset mid-command aborts immediately; engines are reset by their own reset.
//  - FSM INIT->IDLE when axonerve_ready=1. IDLE->INIT if axonerve_ready falls while IDLE (ignored elsewhere).
//  - IDLE, kick=1 (cycle t): latch command/params into cmd_reg; go to LAUNCH. kick outside IDLE ignored.
//  - LAUNCH (t+1): cmd 1 -> sa_kick=1; cmd 2 -> rc_kick=1; both -> RUN.
//    cmd 3 -> CLEAR, clr_cnt=0. Illegal -> DONE with status=1, no engine kicked.
//  - RUN: leaves when engine busy=0, first evaluated in the cycle after the kick pulse
//    (engines assert busy the cycle after kick); -> DONE, status=0.
//  - CLEAR: accum_we=1, accum_din=0, accum_addr=clr_cnt, one entry per cycle. Count N = num_of_words,
//    0 or >2**ADDR_WIDTH clamps to 2**ADDR_WIDTH. After entry N-1 -> DONE, status=0. Latency N+2 from kick.
//  - DONE: done=1 for exactly one cycle, -> IDLE. busy falls in the same cycle as done.
//  - Array mux is keyed on cmd_reg: 1 -> sa_* passthrough; 2 -> rc_addr, we=0, din=0;
//    3 -> clear counter; otherwise addr=0, we=0.
//  - sa_accum_we is forced to 0 whenever cmd_reg!=1 (no stray writes).
//  - Arithmetic: clr_cnt is ADDR_WIDTH+1 bits to cover the full-depth clear without wrap.
//  - status is held until the next command reaches DONE.
// CONFIGURATION
//  WORDCOUNT_CMD_TIMEOUT_EN defined:
//    - RUN counts cycles. At TIMEOUT_CYCLES the FSM goes to DONE with status=2.
//    - The engine is not reset by this block.
//    - A later kick is accepted only once sa_busy=0 and rc_busy=0.
//  Undefined: no counter; RUN waits indefinitely; status=2 is never produced.
// TESTING
//  1. ready=0 for 10 cycles, kick=1 -> busy=1, no kick accepted.
//     Then ready=1 -> IDLE next cycle, busy=0.
//  2. cmd=1, words=16, off=0x1000; sa_busy high 40 cycles.
//     Expect: sa_kick at t+1, sa_num_of_words=16; done 1 cycle after sa_busy falls; status=0.
//  3. cmd=3, words=5 -> accum_we=1 at addrs 0..4, din=0, done at t+7.
//     words=0 -> 16384 writes, last addr 0x3FFF.
//  4. cmd=2, copy_offset=8, words=4 -> rc_kick; rc_offset=8, rc_words=4; accum_we stays 0; accum_addr tracks rc_addr.
//  5. cmd=7 -> no engine kick; done at t+2; status=1.
//     A second kick during busy is ignored.
//  6. TIMEOUT_EN, TIMEOUT_CYCLES=100, sa_busy stuck high -> done and status=2 after 100 RUN cycles.
//     Async reset mid-CLEAR -> accum_we=0 immediately.

Source files
------------

// File: rtl/wordcount_cmd_ctrl.sv
// ---------------------------------------------------------------------------
// wordcount_cmd_ctrl
//
// Command sequencer for the wordcount kernel. It accepts one host command at
// a time and does one of three things:
//   SEARCH_ADD (1) - starts search_and_add_ctrl
//   COPY       (2) - starts simple_result_copy
//   CLEAR      (3) - zeroes accum_array on chip
// It also owns the single port of accum_array and steers that port to
// whichever user the current command needs.
//
// Optional feature (macro WORDCOUNT_CMD_TIMEOUT_EN):
//   - A watchdog ends a RUN that lasts TIMEOUT_CYCLES cycles with status 2.
//   - New kicks are held off until both engines report idle.
// Without the macro there is no watchdog, and RUN waits for the engine
// for as long as it takes.
//
// Ports
//   clk, reset              clock and asynchronous active-high reset
//   axonerve_ready          CAM initialisation complete
//   kick                    command start (accepted in IDLE only)
//   command                 1 SEARCH_ADD, 2 COPY, 3 CLEAR, anything else is illegal
//   num_of_words            word count (SEARCH_ADD/COPY) or entry count (CLEAR, 0 = all)
//   copy_offset             first accum_array entry read by COPY
//   global_memory_offset    host memory byte offset
//   busy                    high while not ready or while a command is in flight
//   done                    one-cycle pulse when a command completes
//   status                  sticky result: 0 OK, 1 illegal command, 2 timeout
//   sa_kick, sa_busy        search_and_add_ctrl start pulse / busy
//   sa_num_of_words, sa_memory_offset            latched engine parameters
//   rc_kick, rc_busy        simple_result_copy start pulse / busy
//   rc_offset, rc_words, rc_memory_offset        latched engine parameters
//   sa_accum_addr/din/we    array port requested by search_and_add_ctrl
//   rc_addr                 read address requested by simple_result_copy
//   accum_addr/din/we       array port driven into accum_array
// ---------------------------------------------------------------------------
module wordcount_cmd_ctrl #(
    parameter int ADDR_WIDTH     = 14,
    parameter int DATA_WIDTH     = 64,
    parameter int TIMEOUT_CYCLES = 1048576
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  axonerve_ready,
    input  logic                  kick,
    input  logic [31:0]           command,
    input  logic [31:0]           num_of_words,
    input  logic [31:0]           copy_offset,
    input  logic [63:0]           global_memory_offset,
    output logic                  busy,
    output logic                  done,
    output logic [1:0]            status,
    output logic                  sa_kick,
    input  logic                  sa_busy,
    output logic [31:0]           sa_num_of_words,
    output logic [63:0]           sa_memory_offset,
    output logic                  rc_kick,
    input  logic                  rc_busy,
    output logic [31:0]           rc_offset,
    output logic [31:0]           rc_words,
    output logic [63:0]           rc_memory_offset,
    input  logic [ADDR_WIDTH-1:0] sa_accum_addr,
    input  logic [DATA_WIDTH-1:0] sa_accum_din,
    input  logic                  sa_accum_we,
    input  logic [ADDR_WIDTH-1:0] rc_addr,
    output logic [ADDR_WIDTH-1:0] accum_addr,
    output logic [DATA_WIDTH-1:0] accum_din,
    output logic                  accum_we
);

    localparam logic [31:0] CMD_SEARCH_ADD = 32'd1;
    localparam logic [31:0] CMD_COPY       = 32'd2;
    localparam logic [31:0] CMD_CLEAR      = 32'd3;

    localparam logic [1:0] STATUS_OK      = 2'd0;
    localparam logic [1:0] STATUS_ILLEGAL = 2'd1;
    localparam logic [1:0] STATUS_TIMEOUT = 2'd2;

    // The clear counter is one bit wider than the address, so a full-depth
    // clear can count to 2**ADDR_WIDTH without wrapping.
    localparam logic [ADDR_WIDTH:0] DEPTH   = {1'b1, {ADDR_WIDTH{1'b0}}};
    localparam logic [ADDR_WIDTH:0] CNT_ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};
    localparam logic [31:0]         DEPTH32 = 32'd1 << ADDR_WIDTH;

    typedef enum logic [2:0] {
        ST_INIT   = 3'd0,
        ST_IDLE   = 3'd1,
        ST_LAUNCH = 3'd2,
        ST_RUN    = 3'd3,
        ST_CLEAR  = 3'd4,
        ST_DONE   = 3'd5
    } state_t;

    // A CLEAR count of 0, or one larger than the array, means the whole array.
    function automatic logic [ADDR_WIDTH:0] clear_count(input logic [31:0] n);
        logic [ADDR_WIDTH:0] len;
        if ((n == 32'd0) || (n > DEPTH32)) begin
            len = DEPTH;
        end else begin
            len = n[ADDR_WIDTH:0];
        end
        return len;
    endfunction

    state_t              state_r, next_state_s;
    logic [31:0]         cmd_r;
    logic [ADDR_WIDTH:0] clr_cnt_r, clr_cnt_s;
    logic [ADDR_WIDTH:0] clr_len_r;
    logic                sa_kick_r, sa_kick_s;
    logic                rc_kick_r, rc_kick_s;
    logic                done_r, done_s;
    logic                busy_r, busy_s;
    logic [1:0]          status_r, status_s;
    logic [31:0]         sa_words_r;
    logic [63:0]         sa_moff_r;
    logic [31:0]         rc_off_r;
    logic [31:0]         rc_words_r;
    logic [63:0]         rc_moff_r;
    logic                latch_s;
    logic                engine_busy_s;
    logic                engines_idle_s;

`ifdef WORDCOUNT_CMD_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] RUN_LIMIT = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [TW-1:0] RUN_ONE   = TW'(1);

    logic [TW-1:0] run_cnt_r, run_cnt_s;

    // A timed-out engine may still be running, so it must finish before the
    // next command can be accepted.
    assign engines_idle_s = ~sa_busy & ~rc_busy;
`else
    // Without the watchdog the limit parameter has no effect.
    logic [31:0] unused_timeout_s;
    assign unused_timeout_s = TIMEOUT_CYCLES;
    assign engines_idle_s   = 1'b1;
`endif

    assign engine_busy_s = (cmd_r == CMD_SEARCH_ADD) ? sa_busy : rc_busy;

    // Next-state and next-output decode for the command FSM.
    always_comb begin
        next_state_s = state_r;
        latch_s      = 1'b0;
        sa_kick_s    = 1'b0;
        rc_kick_s    = 1'b0;
        done_s       = 1'b0;
        status_s     = status_r;
        clr_cnt_s    = clr_cnt_r;
`ifdef WORDCOUNT_CMD_TIMEOUT_EN
        run_cnt_s    = {TW{1'b0}};
`endif
        case (state_r)
            ST_INIT: begin
                if (axonerve_ready) begin
                    next_state_s = ST_IDLE;
                end else begin
                    next_state_s = ST_INIT;
                end
            end
            ST_IDLE: begin
                if (!axonerve_ready) begin
                    next_state_s = ST_INIT;
                end else if (kick && engines_idle_s) begin
                    // The kick pulses are registered, so they are decided
                    // here and appear during the LAUNCH cycle.
                    latch_s      = 1'b1;
                    sa_kick_s    = (command == CMD_SEARCH_ADD);
                    rc_kick_s    = (command == CMD_COPY);
                    next_state_s = ST_LAUNCH;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_LAUNCH: begin
                case (cmd_r)
                    CMD_SEARCH_ADD, CMD_COPY: begin
                        next_state_s = ST_RUN;
                    end
                    CMD_CLEAR: begin
                        next_state_s = ST_CLEAR;
                        clr_cnt_s    = {(ADDR_WIDTH + 1){1'b0}};
                    end
                    default: begin
                        next_state_s = ST_DONE;
                        done_s       = 1'b1;
                        status_s     = STATUS_ILLEGAL;
                    end
                endcase
            end
            ST_RUN: begin
                // The engine raises busy the cycle after its kick, which is
                // the first RUN cycle, so busy is safe to sample here.
                if (!engine_busy_s) begin
                    next_state_s = ST_DONE;
                    done_s       = 1'b1;
                    status_s     = STATUS_OK;
                end
`ifdef WORDCOUNT_CMD_TIMEOUT_EN
                else if (run_cnt_r == RUN_LIMIT) begin
                    next_state_s = ST_DONE;
                    done_s       = 1'b1;
                    status_s     = STATUS_TIMEOUT;
                end else begin
                    run_cnt_s    = run_cnt_r + RUN_ONE;
                    next_state_s = ST_RUN;
                end
`else
                else begin
                    next_state_s = ST_RUN;
                end
`endif
            end
            ST_CLEAR: begin
                if (clr_cnt_r == (clr_len_r - CNT_ONE)) begin
                    next_state_s = ST_DONE;
                    done_s       = 1'b1;
                    status_s     = STATUS_OK;
                end else begin
                    clr_cnt_s    = clr_cnt_r + CNT_ONE;
                    next_state_s = ST_CLEAR;
                end
            end
            ST_DONE: begin
                next_state_s = ST_IDLE;
            end
            default: begin
                next_state_s = ST_INIT;
            end
        endcase
        // busy drops together with the done pulse.
        busy_s = ~((next_state_s == ST_IDLE) | (next_state_s == ST_DONE));
    end

    // FSM state, registered control outputs and latched command parameters.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r    <= ST_INIT;
            cmd_r      <= 32'd0;
            clr_cnt_r  <= {(ADDR_WIDTH + 1){1'b0}};
            clr_len_r  <= {(ADDR_WIDTH + 1){1'b0}};
            sa_kick_r  <= 1'b0;
            rc_kick_r  <= 1'b0;
            done_r     <= 1'b0;
            busy_r     <= 1'b1;
            status_r   <= STATUS_OK;
            sa_words_r <= 32'd0;
            sa_moff_r  <= 64'd0;
            rc_off_r   <= 32'd0;
            rc_words_r <= 32'd0;
            rc_moff_r  <= 64'd0;
        end else begin
            state_r   <= next_state_s;
            clr_cnt_r <= clr_cnt_s;
            sa_kick_r <= sa_kick_s;
            rc_kick_r <= rc_kick_s;
            done_r    <= done_s;
            busy_r    <= busy_s;
            status_r  <= status_s;
            if (latch_s) begin
                cmd_r     <= command;
                clr_len_r <= clear_count(num_of_words);
                // Each engine's parameters change only when that engine is
                // the one being started.
                if (command == CMD_SEARCH_ADD) begin
                    sa_words_r <= num_of_words;
                    sa_moff_r  <= global_memory_offset;
                end else if (command == CMD_COPY) begin
                    rc_off_r   <= copy_offset;
                    rc_words_r <= num_of_words;
                    rc_moff_r  <= global_memory_offset;
                end
            end
        end
    end

`ifdef WORDCOUNT_CMD_TIMEOUT_EN
    // Watchdog counter for the RUN state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            run_cnt_r <= {TW{1'b0}};
        end else begin
            run_cnt_r <= run_cnt_s;
        end
    end
`endif

    // accum_array port steering, selected by the latched command. This is a
    // combinational pass-through, so the engines' array timing is unchanged.
    // Search-and-add writes reach the array only while a SEARCH_ADD command
    // is latched.
    always_comb begin
        accum_addr = {ADDR_WIDTH{1'b0}};
        accum_din  = {DATA_WIDTH{1'b0}};
        accum_we   = 1'b0;
        case (cmd_r)
            CMD_SEARCH_ADD: begin
                accum_addr = sa_accum_addr;
                accum_din  = sa_accum_din;
                accum_we   = sa_accum_we;
            end
            CMD_COPY: begin
                accum_addr = rc_addr;
            end
            CMD_CLEAR: begin
                accum_addr = clr_cnt_r[ADDR_WIDTH-1:0];
                accum_we   = (state_r == ST_CLEAR);
            end
            default: begin
                accum_addr = {ADDR_WIDTH{1'b0}};
            end
        endcase
    end

    assign busy             = busy_r;
    assign done             = done_r;
    assign status           = status_r;
    assign sa_kick          = sa_kick_r;
    assign rc_kick          = rc_kick_r;
    assign sa_num_of_words  = sa_words_r;
    assign sa_memory_offset = sa_moff_r;
    assign rc_offset        = rc_off_r;
    assign rc_words         = rc_words_r;
    assign rc_memory_offset = rc_moff_r;

endmodule

// File: tb/tb_wordcount_cmd_ctrl.sv
// ---------------------------------------------------------------------------
// tb_wordcount_cmd_ctrl
//
// Scoreboard bench for wordcount_cmd_ctrl. Stimulus tasks issue directed
// commands and queue the expected engine kicks, array writes and done
// pulses. A monitor on the falling clock edge takes each event the DUT
// presents and compares it with the next queued expectation.
// ---------------------------------------------------------------------------
module tb_wordcount_cmd_ctrl;

    localparam int AW = 14;
    localparam int DW = 64;

    logic          clk;
    logic          reset;
    logic          axonerve_ready;
    logic          kick;
    logic [31:0]   command;
    logic [31:0]   num_of_words;
    logic [31:0]   copy_offset;
    logic [63:0]   global_memory_offset;
    logic          busy;
    logic          done;
    logic [1:0]    status;
    logic          sa_kick;
    logic          sa_busy;
    logic [31:0]   sa_num_of_words;
    logic [63:0]   sa_memory_offset;
    logic          rc_kick;
    logic          rc_busy;
    logic [31:0]   rc_offset;
    logic [31:0]   rc_words;
    logic [63:0]   rc_memory_offset;
    logic [AW-1:0] sa_accum_addr;
    logic [DW-1:0] sa_accum_din;
    logic          sa_accum_we;
    logic [AW-1:0] rc_addr;
    logic [AW-1:0] accum_addr;
    logic [DW-1:0] accum_din;
    logic          accum_we;

    wordcount_cmd_ctrl #(
        .ADDR_WIDTH    (AW),
        .DATA_WIDTH    (DW),
        .TIMEOUT_CYCLES(100)
    ) dut (
        .clk                 (clk),
        .reset               (reset),
        .axonerve_ready      (axonerve_ready),
        .kick                (kick),
        .command             (command),
        .num_of_words        (num_of_words),
        .copy_offset         (copy_offset),
        .global_memory_offset(global_memory_offset),
        .busy                (busy),
        .done                (done),
        .status              (status),
        .sa_kick             (sa_kick),
        .sa_busy             (sa_busy),
        .sa_num_of_words     (sa_num_of_words),
        .sa_memory_offset    (sa_memory_offset),
        .rc_kick             (rc_kick),
        .rc_busy             (rc_busy),
        .rc_offset           (rc_offset),
        .rc_words            (rc_words),
        .rc_memory_offset    (rc_memory_offset),
        .sa_accum_addr       (sa_accum_addr),
        .sa_accum_din        (sa_accum_din),
        .sa_accum_we         (sa_accum_we),
        .rc_addr             (rc_addr),
        .accum_addr          (accum_addr),
        .accum_din           (accum_din),
        .accum_we            (accum_we)
    );

    typedef struct {
        int         cyc;
        logic [1:0] st;
    } done_e_t;

    typedef struct {
        int          cyc;
        logic        is_sa;
        logic [31:0] words;
        logic [31:0] off;
        logic [63:0] moff;
    } kick_e_t;

    typedef struct {
        int            cyc;
        logic [AW-1:0] addr;
        logic [DW-1:0] din;
    } wr_e_t;

    done_e_t done_q[$];
    kick_e_t kick_q[$];
    wr_e_t   wr_q[$];

    int n_checks  = 0;
    int n_errors  = 0;
    int cyc       = 0;
    int done_cnt  = 0;
    bit ignore_wr = 1'b0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // Monitor: every DUT event is matched against the head of its queue.
    always @(negedge clk) begin
        done_e_t de;
        kick_e_t ke;
        wr_e_t   we;
        if (!reset) begin
            if (done) begin
                done_cnt++;
                if (done_q.size() == 0) begin
                    chk("done_unexpected", 64'd1, 64'd0);
                end else begin
                    de = done_q.pop_front();
                    chk("done_cycle", 64'(cyc), 64'(de.cyc));
                    chk("done_status", 64'(status), 64'(de.st));
                    chk("busy_at_done", 64'(busy), 64'd0);
                end
            end
            if (sa_kick || rc_kick) begin
                if (kick_q.size() == 0) begin
                    chk("kick_unexpected", 64'd1, 64'd0);
                end else begin
                    ke = kick_q.pop_front();
                    chk("kick_cycle", 64'(cyc), 64'(ke.cyc));
                    chk("kick_which", 64'({sa_kick, rc_kick}), ke.is_sa ? 64'd2 : 64'd1);
                    if (ke.is_sa) begin
                        chk("sa_num_of_words", 64'(sa_num_of_words), 64'(ke.words));
                        chk("sa_memory_offset", sa_memory_offset, ke.moff);
                    end else begin
                        chk("rc_words", 64'(rc_words), 64'(ke.words));
                        chk("rc_offset", 64'(rc_offset), 64'(ke.off));
                        chk("rc_memory_offset", rc_memory_offset, ke.moff);
                    end
                end
            end
            if (accum_we && !ignore_wr) begin
                if (wr_q.size() == 0) begin
                    chk("write_unexpected", 64'(accum_addr), 64'hFFFF_FFFF);
                end else begin
                    we = wr_q.pop_front();
                    chk("write_cycle", 64'(cyc), 64'(we.cyc));
                    chk("write_addr", 64'(accum_addr), 64'(we.addr));
                    chk("write_din", accum_din, we.din);
                end
            end
        end
    end

    // Wait until the monitor has seen one more done pulse; returns in the
    // following (IDLE) cycle.
    task automatic wait_done(input int budget);
        int start;
        bit seen;
        start = done_cnt;
        seen  = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(posedge clk);
            #1;
            if (done_cnt > start) seen = 1'b1;
        end
        if (!seen) chk("done_wait_expired", 64'd0, 64'd1);
    endtask

    // Present a command for one cycle; t is the cycle in which kick is high.
    task automatic issue(input logic [31:0] c, input logic [31:0] w, input logic [31:0] co,
                         input logic [63:0] m, output int t);
        command              = c;
        num_of_words         = w;
        copy_offset          = co;
        global_memory_offset = m;
        kick                 = 1'b1;
        t                    = cyc;
        if (c == 32'd1) kick_q.push_back(kick_e_t'{t + 1, 1'b1, w, 32'd0, m});
        else if (c == 32'd2) kick_q.push_back(kick_e_t'{t + 1, 1'b0, w, co, m});
        @(posedge clk);
        #1;
        kick = 1'b0;
    endtask

    // SEARCH_ADD whose engine stays busy for len cycles. With extras set,
    // one engine write is passed through and a stray kick is tried mid-run.
    task automatic run_sa(input logic [31:0] w, input logic [63:0] m, input int len, input bit extras);
        int t;
        issue(32'd1, w, 32'd0, m, t);
        done_q.push_back(done_e_t'{t + 3 + len, 2'd0});
        @(posedge clk);
        #1;
        sa_busy = 1'b1;
        for (int i = 0; i < len; i++) begin
            if (i == 0) chk("busy_in_run", 64'(busy), 64'd1);
            if (extras && i == 3) begin
                sa_accum_we   = 1'b1;
                sa_accum_addr = 14'h0123;
                sa_accum_din  = 64'hDEAD_BEEF_0000_0042;
                wr_q.push_back(wr_e_t'{cyc, 14'h0123, 64'hDEAD_BEEF_0000_0042});
                command       = 32'd3;
                num_of_words  = 32'd3;
                kick          = 1'b1;
            end else begin
                sa_accum_we = 1'b0;
                kick        = 1'b0;
            end
            @(posedge clk);
            #1;
        end
        sa_accum_we = 1'b0;
        kick        = 1'b0;
        sa_busy     = 1'b0;
        wait_done(20);
    endtask

    task automatic run_clear(input logic [31:0] n);
        int t;
        int len;
        issue(32'd3, n, 32'd0, 64'd0, t);
        len = (n == 32'd0 || n > 32'd16384) ? 16384 : int'(n);
        for (int i = 0; i < len; i++) begin
            wr_q.push_back(wr_e_t'{t + 2 + i, 14'(i), 64'd0});
        end
        done_q.push_back(done_e_t'{t + len + 2, 2'd0});
        wait_done(len + 10);
    endtask

    // COPY with the engine busy for len cycles; the search engine tries to
    // write throughout, which must not reach the array.
    task automatic run_rc(input logic [31:0] co, input logic [31:0] w, input logic [63:0] m, input int len);
        int t;
        logic [AW-1:0] a;
        issue(32'd2, w, co, m, t);
        done_q.push_back(done_e_t'{t + 3 + len, 2'd0});
        sa_accum_we   = 1'b1;
        sa_accum_addr = 14'h02AA;
        sa_accum_din  = 64'h5A5A;
        @(posedge clk);
        #1;
        rc_busy = 1'b1;
        for (int i = 0; i < len; i++) begin
            a       = 14'(256 + int'(co) + 7 * i);
            rc_addr = a;
            #1;
            chk("accum_addr_tracks_rc", 64'(accum_addr), 64'(a));
            chk("accum_we_copy", 64'(accum_we), 64'd0);
            @(posedge clk);
            #1;
        end
        rc_busy     = 1'b0;
        sa_accum_we = 1'b0;
        wait_done(20);
    endtask

    initial begin
        int t;
        reset                = 1'b1;
        axonerve_ready       = 1'b0;
        kick                 = 1'b0;
        command              = 32'd0;
        num_of_words         = 32'd0;
        copy_offset          = 32'd0;
        global_memory_offset = 64'd0;
        sa_busy              = 1'b0;
        rc_busy              = 1'b0;
        sa_accum_addr        = 14'd0;
        sa_accum_din         = 64'd0;
        sa_accum_we          = 1'b0;
        rc_addr              = 14'd0;
        #2;
        chk("reset_busy", 64'(busy), 64'd1);
        chk("reset_done", 64'(done), 64'd0);
        chk("reset_status", 64'(status), 64'd0);
        chk("reset_sa_kick", 64'(sa_kick), 64'd0);
        chk("reset_rc_kick", 64'(rc_kick), 64'd0);
        chk("reset_accum_we", 64'(accum_we), 64'd0);
        chk("reset_accum_addr", 64'(accum_addr), 64'd0);
        chk("reset_sa_words", 64'(sa_num_of_words), 64'd0);
        chk("reset_rc_offset", 64'(rc_offset), 64'd0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;

        // Not ready: kicks are ignored and busy stays high.
        command      = 32'd1;
        num_of_words = 32'd16;
        kick         = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        chk("busy_not_ready", 64'(busy), 64'd1);
        kick           = 1'b0;
        axonerve_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("busy_after_ready", 64'(busy), 64'd0);

        // Ready falling in IDLE returns to INIT.
        axonerve_ready = 1'b0;
        @(posedge clk);
        #1;
        chk("busy_ready_drop", 64'(busy), 64'd1);
        axonerve_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("busy_ready_back", 64'(busy), 64'd0);

        run_sa(32'd16, 64'h1000, 40, 1'b1);
        run_clear(32'd5);
        run_clear(32'd0);
        run_clear(32'd20000);
        run_rc(32'd8, 32'd4, 64'h2000, 6);

        // Illegal command, with a second kick tried while busy.
        issue(32'd7, 32'd9, 32'd0, 64'd0, t);
        done_q.push_back(done_e_t'{t + 2, 2'd1});
        command      = 32'd3;
        num_of_words = 32'd2;
        kick         = 1'b1;
        @(posedge clk);
        #1;
        kick = 1'b0;
        wait_done(10);
        repeat (3) @(posedge clk);
        #1;
        chk("status_sticky", 64'(status), 64'd1);
        run_clear(32'd2);
        chk("status_after_ok", 64'(status), 64'd0);

`ifdef WORDCOUNT_CMD_TIMEOUT_EN
        // Stuck engine: watchdog ends RUN after 100 cycles with status 2.
        issue(32'd1, 32'd5, 32'd0, 64'h40, t);
        done_q.push_back(done_e_t'{t + 102, 2'd2});
        @(posedge clk);
        #1;
        sa_busy = 1'b1;
        wait_done(300);
        chk("status_timeout", 64'(status), 64'd2);
        command      = 32'd3;
        num_of_words = 32'd2;
        kick         = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("kick_held_engine_busy", 64'(busy), 64'd0);
        kick    = 1'b0;
        sa_busy = 1'b0;
        @(posedge clk);
        #1;
`else
        // No watchdog: a long engine run still completes with status 0.
        run_sa(32'd5, 64'h40, 150, 1'b0);
`endif

        // Asynchronous reset in the middle of a CLEAR.
        issue(32'd3, 32'd100, 32'd0, 64'd0, t);
        ignore_wr = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        chk("clear_we_active", 64'(accum_we), 64'd1);
        #2;
        reset = 1'b1;
        #1;
        chk("reset_mid_clear_we", 64'(accum_we), 64'd0);
        chk("reset_mid_clear_addr", 64'(accum_addr), 64'd0);
        chk("reset_mid_clear_busy", 64'(busy), 64'd1);
        @(posedge clk);
        #1;
        reset     = 1'b0;
        ignore_wr = 1'b0;
        @(posedge clk);
        #1;
        chk("busy_after_reset", 64'(busy), 64'd0);
        chk("status_after_reset", 64'(status), 64'd0);
        chk("sa_words_after_reset", 64'(sa_num_of_words), 64'd0);

        repeat (5) @(posedge clk);
        #1;
        chk("done_queue_empty", 64'(done_q.size()), 64'd0);
        chk("kick_queue_empty", 64'(kick_q.size()), 64'd0);
        chk("write_queue_empty", 64'(wr_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL global_time_limit: simulation did not complete");
        $fatal(1);
    end

endmodule
